demux1to4_stream: RTL and testbench



---
 rtl/demux1to4_stream.sv | 77 +++++++
 tb/tb_demux1to4_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_stream.sv
// rtl/demux1to4_stream.sv - 1:4 valid/ready stream demux with registered lane slots
// Optional per-lane delivered-beat counters when DEMUX4_CNT_EN is defined.
module demux1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX4_CNT_EN
    ,
    output logic [4*16-1:0]    beat_cnt
`endif
);

    logic [3:0]       full;
    logic [WIDTH-1:0] slot [4];
    logic [3:0]       drain;
    logic             accept;

    // A full lane can still take a beat if its consumer empties it this cycle.
    assign in_ready = ~full[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign drain    = full & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (in_sel == 2'(i))) begin
                    slot[i] <= in_data;
                    full[i] <= 1'b1;
                end else if (drain[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = full;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign out_data[g*WIDTH +: WIDTH] = slot[g];
    end

`ifdef DEMUX4_CNT_EN
    logic [15:0] cnt [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (drain[i]) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign beat_cnt[g*16 +: 16] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_demux1to4_stream.sv
// tb/tb_demux1to4_stream.sv - directed table, sequences and random stimulus for demux1to4_stream
// Covers DEMUX4_CNT_EN counters when that macro is defined.
module tb_demux1to4_stream;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
`ifdef DEMUX4_CNT_EN
    logic [63:0] beat_cnt;
`endif

    always #5 clk = ~clk;

    demux1to4_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX4_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each lane is a FIFO of pending beats plus the last value delivered.
    logic [7:0]  mq [4][$];
    logic [7:0]  last_data [4];
    logic [15:0] dcnt [4];

    logic        hold_prev = 1'b0;
    logic        pv;
    logic [1:0]  ps;
    logic [7:0]  pd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            last_data[i] = 8'h00;
            dcnt[i] = 16'h0000;
        end
    endfunction

    function automatic logic m_ready(input logic [1:0] s, input logic [3:0] rd);
        return (mq[s].size() == 0) || rd[s];
    endfunction

    function automatic logic [3:0] m_valid();
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = (mq[i].size() != 0);
        return v;
    endfunction

    function automatic logic [31:0] m_data();
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = (mq[i].size() != 0) ? mq[i][0] : last_data[i];
        return d;
    endfunction

    function automatic logic [63:0] m_cnt();
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) c[i*16 +: 16] = dcnt[i];
        return c;
    endfunction

    function automatic void m_step(input logic r, input logic v, input logic [1:0] s,
                                   input logic [7:0] d, input logic [3:0] rd);
        logic acc;
        if (r) begin
            m_reset();
        end else begin
            acc = v && m_ready(s, rd);
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0 && rd[i]) begin
                    last_data[i] = mq[i].pop_front();
                    dcnt[i] = dcnt[i] + 16'd1;
                end
            end
            if (acc) mq[s].push_back(d);
        end
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, " out_valid"}, {60'd0, out_valid}, {60'd0, m_valid()});
        check({tag, " out_data"}, {32'd0, out_data}, {32'd0, m_data()});
`ifdef DEMUX4_CNT_EN
        check({tag, " beat_cnt"}, beat_cnt, m_cnt());
`endif
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] rd,
                         input bit full_check, output logic rdy_seen);
        logic exp_rdy;
        if (hold_prev && !r) begin
            checks++;
            if (v !== pv || s !== ps || d !== pd) begin
                errors++;
                $display("FAIL stability: valid/sel/data changed while stalled");
            end
        end
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = rd;
        #4;
        exp_rdy = m_ready(s, rd);
        rdy_seen = in_ready;
        if (!r) check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        @(posedge clk);
        m_step(r, v, s, d, rd);
        hold_prev = !r && v && !exp_rdy;
        pv = v; ps = s; pd = d;
        #1;
        if (full_check) compare_outputs("model");
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] rd;
        logic       exp_rdy;
        logic [3:0] exp_valid;
        logic [1:0] lane;
        logic [7:0] exp_lane;
    } vec_t;

    vec_t tbl [18];
    logic rdy;
    logic v_r;
    logic [1:0] s_r;
    logic [7:0] d_r;

    initial begin
        // routing, pass-through, head-of-line stall, then fill all lanes and reset mid-operation
        tbl[0]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2'd2, 8'hA5};
        tbl[1]  = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 4'b0000, 2'd2, 8'hA5};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 8'h01, 4'b0010, 1'b1, 4'b0010, 2'd1, 8'h01};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h02, 4'b0010, 1'b1, 4'b0010, 2'd1, 8'h02};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h03, 4'b0010, 1'b1, 4'b0010, 2'd1, 8'h03};
        tbl[5]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 4'b0000, 2'd1, 8'h03};
        tbl[6]  = '{1'b0, 1'b1, 2'd3, 8'h33, 4'b0000, 1'b1, 4'b1000, 2'd3, 8'h33};
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 8'h10, 4'b0000, 1'b1, 4'b1001, 2'd0, 8'h10};
        tbl[8]  = '{1'b0, 1'b1, 2'd3, 8'h44, 4'b0000, 1'b0, 4'b1001, 2'd3, 8'h33};
        tbl[9]  = '{1'b0, 1'b1, 2'd3, 8'h44, 4'b0001, 1'b0, 4'b1000, 2'd0, 8'h10};
        tbl[10] = '{1'b0, 1'b1, 2'd3, 8'h44, 4'b1000, 1'b1, 4'b1000, 2'd3, 8'h44};
        tbl[11] = '{1'b0, 1'b0, 2'd3, 8'h00, 4'b1000, 1'b1, 4'b0000, 2'd3, 8'h44};
        tbl[12] = '{1'b0, 1'b1, 2'd0, 8'hB0, 4'b0000, 1'b1, 4'b0001, 2'd0, 8'hB0};
        tbl[13] = '{1'b0, 1'b1, 2'd1, 8'hB1, 4'b0000, 1'b1, 4'b0011, 2'd1, 8'hB1};
        tbl[14] = '{1'b0, 1'b1, 2'd2, 8'hB2, 4'b0000, 1'b1, 4'b0111, 2'd2, 8'hB2};
        tbl[15] = '{1'b0, 1'b1, 2'd3, 8'hB3, 4'b0000, 1'b1, 4'b1111, 2'd3, 8'hB3};
        tbl[16] = '{1'b1, 1'b1, 2'd1, 8'hCC, 4'b0000, 1'b0, 4'b0000, 2'd1, 8'h00};
        tbl[17] = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b0000, 1'b1, 4'b0000, 2'd1, 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rst = 1'b0;
        #1;
        check("reset out_valid", {60'd0, out_valid}, 64'd0);
        check("reset out_data", {32'd0, out_data}, 64'd0);
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
`ifdef DEMUX4_CNT_EN
        check("reset beat_cnt", beat_cnt, 64'd0);
`endif
        @(posedge clk);
        #1;

        for (int k = 0; k < 18; k++) begin
            cycle(tbl[k].r, tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].rd, 1'b1, rdy);
            if (!tbl[k].r) check($sformatf("vec%0d in_ready", k), {63'd0, rdy}, {63'd0, tbl[k].exp_rdy});
            check($sformatf("vec%0d out_valid", k), {60'd0, out_valid}, {60'd0, tbl[k].exp_valid});
            check($sformatf("vec%0d lane%0d data", k, tbl[k].lane),
                  {56'd0, out_data[tbl[k].lane*8 +: 8]}, {56'd0, tbl[k].exp_lane});
        end
        check("post-reset all lanes zero", {32'd0, out_data}, 64'd0);

`ifdef DEMUX4_CNT_EN
        // pass-through section drained three beats on lane1 before the reset cleared them
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, rdy);
        for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b1, 2'd1, 8'(k), 4'b0010, 1'b0, rdy);
        cycle(1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, rdy);
        check("lane1 beat_cnt after 3", {48'd0, beat_cnt[16 +: 16]}, 64'd3);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic r;
            r = ($urandom_range(0, 199) == 0);
            if (!hold_prev) begin
                v_r = ($urandom_range(0, 3) != 0);
                s_r = 2'($urandom_range(0, 3));
                d_r = 8'($urandom);
            end
            cycle(r, v_r, s_r, d_r, 4'($urandom), 1'b1, rdy);
        end

`ifdef DEMUX4_CNT_EN
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, rdy);
        for (int n = 0; n < 65536; n++) cycle(1'b0, 1'b1, 2'd0, 8'(n), 4'b0001, 1'b0, rdy);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, rdy);
        check("wrap lane0 beat_cnt", {48'd0, beat_cnt[15:0]}, 64'd0);
        check("wrap lanes1-3 beat_cnt", {16'd0, beat_cnt[63:16]}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
